// File: rtl/pipe_stage_chain_if.sv
// pipe_stage_chain_if: input item, hold/kill controls and per-stage views of the latch chain
interface pipe_stage_chain_if #(
  parameter int STAGES = 4,
  parameter int DATA_W = 16,
  parameter int CTRL_W = 22,
  parameter int CNT_W  = 16
);
  logic                     in_valid;
  logic [DATA_W-1:0]        in_data;
  logic [CTRL_W-1:0]        in_ctrl;
  logic                     in_ready;
  logic [STAGES-1:0]        hold;
  logic [STAGES:0]          kill;
  logic [STAGES-1:0]        stage_valid;
  logic [STAGES*DATA_W-1:0] stage_data;
  logic [STAGES*CTRL_W-1:0] stage_ctrl;
  logic                     out_valid;
  logic                     out_fire;
  logic [CNT_W-1:0]         retire_cnt;
  logic [CNT_W-1:0]         kill_cnt;
  modport master (
    output in_valid, in_data, in_ctrl, hold, kill,
    input  in_ready, stage_valid, stage_data, stage_ctrl, out_valid, out_fire, retire_cnt, kill_cnt
  );
  modport slave (
    input  in_valid, in_data, in_ctrl, hold, kill,
    output in_ready, stage_valid, stage_data, stage_ctrl, out_valid, out_fire, retire_cnt, kill_cnt
  );
endinterface

// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: pipeline latch chain with per-stage hold/kill, bubble insertion and debug counters
module pipe_stage_chain #(
  parameter int          STAGES   = 4,
  parameter int          DATA_W   = 16,
  parameter int          CTRL_W   = 22,
  parameter logic [15:0] NOP_DATA = 16'h0800,
  parameter int          CNT_W    = 16
) (
  input logic               clk,
  input logic               rst,
  pipe_stage_chain_if.slave bus
);
  localparam logic [DATA_W-1:0] NOP = DATA_W'(NOP_DATA);
  localparam int KW = $clog2(STAGES + 2);
  localparam int SW = CNT_W + KW;
  logic [STAGES-1:0]              r_valid;
  logic [STAGES-1:0][DATA_W-1:0]  r_data;
  logic [STAGES-1:0][CTRL_W-1:0]  r_ctrl;
  logic [CNT_W-1:0]               r_ret;
  logic [CNT_W-1:0]               r_kill;
  logic [STAGES-1:0]              w_heff;
  logic [STAGES-1:0]              w_nv;
  logic [STAGES-1:0][DATA_W-1:0]  w_nd;
  logic [STAGES-1:0][CTRL_W-1:0]  w_nc;
  logic [STAGES:0]                w_kv;
  logic [KW-1:0]                  w_kadd;
  logic [SW-1:0]                  w_ksum;
  logic                           w_fire;
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    logic              w_sv;
    logic              w_sk;
    logic [DATA_W-1:0] w_sd;
    logic [CTRL_W-1:0] w_sc;
    if (k == 0) begin : g_head
      assign w_sv = w_heff[0] ? r_valid[0] : bus.in_valid;
      assign w_sk = w_heff[0] ? bus.kill[0] : bus.kill[STAGES];
      assign w_sd = w_heff[0] ? r_data[0] : bus.in_data;
      assign w_sc = w_heff[0] ? r_ctrl[0] : bus.in_ctrl;
    end else begin : g_body
      // a stage just above a stall boundary takes a bubble, not the frozen item below
      assign w_sv = w_heff[k] ? r_valid[k] : ~w_heff[k-1] & r_valid[k-1];
      assign w_sk = w_heff[k] ? bus.kill[k] : bus.kill[k-1];
      assign w_sd = w_heff[k] ? r_data[k] : r_data[k-1];
      assign w_sc = w_heff[k] ? r_ctrl[k] : r_ctrl[k-1];
    end
    assign w_heff[k] = |(bus.hold >> k);
    assign w_nv[k]   = w_sv & ~w_sk;
    assign w_nd[k]   = w_nv[k] ? w_sd : NOP;
    assign w_nc[k]   = w_nv[k] ? w_sc : '0;
  end
  assign w_fire = r_valid[STAGES-1] & ~bus.hold[STAGES-1];
  assign w_kv   = bus.kill & {bus.in_valid & ~w_heff[0], r_valid};
  always_comb begin
    w_kadd = '0;
    for (int k = 0; k <= STAGES; k++) w_kadd = w_kadd + KW'(w_kv[k]);
  end
  assign w_ksum = SW'(r_kill) + SW'(w_kadd);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_data  <= {STAGES{NOP}};
      r_ctrl  <= '0;
      r_ret   <= '0;
      r_kill  <= '0;
    end else begin
      r_valid <= w_nv;
      r_data  <= w_nd;
      r_ctrl  <= w_nc;
      r_ret   <= r_ret + CNT_W'(w_fire & ~&r_ret);
      r_kill  <= (w_ksum > SW'({CNT_W{1'b1}})) ? '1 : w_ksum[CNT_W-1:0];
    end
  end
  assign bus.in_ready    = ~w_heff[0];
  assign bus.stage_valid = r_valid;
  assign bus.stage_data  = r_data;
  assign bus.stage_ctrl  = r_ctrl;
  assign bus.out_valid   = r_valid[STAGES-1];
  assign bus.out_fire    = w_fire;
  assign bus.retire_cnt  = r_ret;
  assign bus.kill_cnt    = r_kill;
endmodule

// File: tb/tb_pipe_stage_chain.sv
// tb_pipe_stage_chain: directed checks of streaming, stalls, flushes, backpressure, saturation and async reset
module tb_pipe_stage_chain;
  localparam int ST = 4;
  localparam int DW = 16;
  localparam int CW = 22;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_pass = 0;
  always #5 clk = ~clk;
  pipe_stage_chain_if #(.STAGES(ST), .DATA_W(DW), .CTRL_W(CW), .CNT_W(16)) bus ();
  pipe_stage_chain_if #(.STAGES(ST), .DATA_W(DW), .CTRL_W(CW), .CNT_W(3))  sbus ();
  assign sbus.in_valid = bus.in_valid;
  assign sbus.in_data  = bus.in_data;
  assign sbus.in_ctrl  = bus.in_ctrl;
  assign sbus.hold     = bus.hold;
  assign sbus.kill     = bus.kill;
  pipe_stage_chain #(.STAGES(ST), .DATA_W(DW), .CTRL_W(CW), .NOP_DATA(16'h0800), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  pipe_stage_chain #(.STAGES(ST), .DATA_W(DW), .CTRL_W(CW), .NOP_DATA(16'h0800), .CNT_W(3)) u_sat (
    .clk(clk), .rst(rst), .bus(sbus)
  );
  function automatic logic [DW-1:0] sd(input int k);
    return bus.stage_data[k*DW +: DW];
  endfunction
  function automatic logic [CW-1:0] sc(input int k);
    return bus.stage_ctrl[k*CW +: CW];
  endfunction
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drv(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                     input logic [ST-1:0] h, input logic [ST:0] k);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_ctrl  = c;
    bus.hold     = h;
    bus.kill     = k;
    #1;
  endtask
  initial begin
    drv(0, '0, '0, '0, '0);
    tick;
    tick;
    chk("rst_valid", bus.stage_valid, 4'b0000);
    chk("rst_data", bus.stage_data, {4{16'h0800}});
    chk("rst_ctrl", bus.stage_ctrl, 88'h0);
    chk("rst_cnts", {bus.retire_cnt, bus.kill_cnt}, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      drv(i < 5, 16'h1111 + 16'(i) * 16'h0111, 22'(i + 1), '0, '0);
      chk("stream_ready", bus.in_ready, 1'b1);
      tick;
      if (i == 2) chk("stream_latency", bus.out_valid, 1'b0);
      if (i >= 3 && i <= 7)
        chk("stream_out", {bus.out_valid, sd(3), sc(3)}, {1'b1, 16'h1111 + 16'(i - 3) * 16'h0111, 22'(i - 2)});
    end
    chk("stream_retire", bus.retire_cnt, 16'd5);
    chk("stream_empty", bus.stage_valid, 4'b0000);
    for (int i = 0; i < 4; i++) begin
      drv(1, 16'h2001 + 16'(i), 22'h11 + 22'(i), '0, '0);
      tick;
    end
    drv(1, 16'h2005, 22'h15, 4'b0010, '0);
    chk("stall_ready", bus.in_ready, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick;
      chk("stall_bubble", {bus.stage_valid[2], sd(2), sc(2)}, {1'b0, 16'h0800, 22'h0});
      chk("stall_frozen", {bus.stage_valid[1:0], sd(1), sd(0)}, {2'b11, 16'h2003, 16'h2004});
      if (i == 0) chk("stall_adv", {bus.out_valid, sd(3)}, {1'b1, 16'h2002});
    end
    chk("stall_out_bubble", {bus.out_valid, sd(3)}, {1'b0, 16'h0800});
    drv(1, 16'h2005, 22'h15, '0, '0);
    tick;
    chk("resume_fill", {bus.stage_valid, sd(2), sd(1), sd(0)}, {4'b0111, 16'h2003, 16'h2004, 16'h2005});
    drv(0, '0, '0, '0, '0);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("resume_out", {bus.out_valid, sd(3)}, {1'b1, 16'h2003 + 16'(i)});
    end
    tick;
    chk("resume_retire", {bus.stage_valid, bus.retire_cnt}, {4'b0000, 16'd10});
    drv(1, 16'h3003, 22'h3, '0, '0);
    tick;
    drv(1, 16'h3002, 22'h2, '0, '0);
    tick;
    drv(1, 16'h3001, 22'h1, '0, '0);
    tick;
    drv(0, '0, '0, '0, 5'b00011);
    tick;
    chk("flush_valid", bus.stage_valid, 4'b1000);
    chk("flush_bubbles", {sd(2), sd(1), sc(2), sc(1)}, {16'h0800, 16'h0800, 22'h0, 22'h0});
    chk("flush_survivor", {sd(3), sc(3)}, {16'h3003, 22'h3});
    chk("flush_kill_cnt", bus.kill_cnt, 16'd2);
    drv(0, '0, '0, '0, '0);
    tick;
    chk("flush_retire", bus.retire_cnt, 16'd11);
    drv(1, 16'h5001, 22'h5, '0, '0);
    tick;
    drv(0, '0, '0, '0, '0);
    tick;
    tick;
    tick;
    chk("bp_fire_free", bus.out_fire, 1'b1);
    drv(0, '0, '0, 4'b1000, '0);
    chk("bp_fire_held", {bus.out_fire, bus.in_ready}, 2'b00);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("bp_stable", {bus.out_valid, bus.out_fire, sd(3), bus.retire_cnt}, {1'b1, 1'b0, 16'h5001, 16'd11});
    end
    drv(1, 16'h4444, 22'h4, 4'b1000, 5'b10000);
    chk("kin_ready", bus.in_ready, 1'b0);
    tick;
    chk("kin_nothing", {bus.stage_valid, bus.kill_cnt}, {4'b1000, 16'd2});
    drv(0, '0, '0, 4'b1000, 5'b01000);
    tick;
    chk("holdkill", {bus.stage_valid, sd(3), bus.kill_cnt, bus.retire_cnt}, {4'b0000, 16'h0800, 16'd3, 16'd11});
    drv(1, 16'h4444, 22'h4, '0, 5'b10000);
    chk("kin_ready_free", bus.in_ready, 1'b1);
    tick;
    chk("kin_killed", {bus.stage_valid, bus.kill_cnt}, {4'b0000, 16'd4});
    chk("sat_retire", sbus.retire_cnt, 3'd7);
    chk("sat_kill", sbus.kill_cnt, 3'd4);
    drv(1, 16'h6001, 22'h6, '0, '0);
    tick;
    tick;
    tick;
    chk("mid_valid", bus.stage_valid, 4'b0111);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_valid", {bus.stage_valid, sbus.stage_valid}, 8'h00);
    chk("arst_data", bus.stage_data, {4{16'h0800}});
    chk("arst_ctrl", bus.stage_ctrl, 88'h0);
    chk("arst_cnts", {bus.retire_cnt, bus.kill_cnt, sbus.retire_cnt, sbus.kill_cnt}, 38'h0);
    drv(0, '0, '0, '0, '0);
    tick;
    rst = 1'b0;
    tick;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
